// File: rtl/secded_arq_replay_fifo.sv
`default_nettype none
// ============================================================================
// Module      : secded_arq_replay_fifo
// Description : SECDED-protected FIFO. Each read passes through an error
//               injection channel and a SECDED decoder. Uncorrectable reads
//               are re-fetched automatically until the retry budget runs out.
// Revision    : 1.0 - initial release
// ============================================================================
module secded_arq_replay_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_WIDTH  = 8,
    localparam int c_PAR_W   = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int c_CW      = DATA_WIDTH + c_PAR_W + 1,
    localparam int c_POS_W   = $clog2(c_CW),
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [1:0]            err_mode,
    input  logic [c_POS_W-1:0]    err_pos,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ack,
    output logic                  nack,
    output logic                  drop,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [c_CNT_W-1:0]    count,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;

    // Bit 0 holds overall parity; bits 1..CW-1 are Hamming positions.
    function automatic logic [c_CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [c_CW-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i < c_CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k = k + 1;
            end
        end
        for (int b = 0; b < c_PAR_W; b++) begin
            for (int i = 1; i < c_CW; i++) begin
                if (((i >> b) & 1) == 1 && i != (1 << b)) c[1 << b] = c[1 << b] ^ c[i];
            end
        end
        c[0] = ^c;
        return c;
    endfunction

    logic [c_CW-1:0]       r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr, r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [1:0]            r_state;
    logic [c_ATT_W-1:0]    r_attempt;
    logic [c_CW-1:0]       r_cw;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ack, r_nack, r_drop, r_overflow;
    logic [CNT_WIDTH-1:0]  r_corr, r_uncorr;

    logic [c_CW-1:0]       w_one, w_two, w_mask;
    logic [c_PAR_W-1:0]    w_syn;
    logic                  w_par, w_single, w_double;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_push, w_pop;

    // Out-of-range err_pos matches no bit, so it naturally yields a clean mask.
    always_comb begin
        w_one = '0;
        w_two = '0;
        for (int i = 0; i < c_CW; i++) begin
            w_one[i] = (int'(err_pos) == i);
            w_two[i] = w_one[i] || (int'(err_pos) + 1 == i) ||
                       (int'(err_pos) == c_CW - 1 && i == 0);
        end
        case (err_mode)
            2'b01:   w_mask = w_one;
            2'b10:   w_mask = w_two;
            2'b11:   w_mask = (r_attempt == '0) ? w_two : '0;
            default: w_mask = '0;
        endcase
    end

    always_comb begin
        int k;
        w_syn  = '0;
        w_data = '0;
        k      = 0;
        for (int i = 1; i < c_CW; i++) begin
            if (r_cw[i]) w_syn = w_syn ^ c_PAR_W'(i);
        end
        for (int i = 1; i < c_CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                w_data[k] = r_cw[i] ^ (w_syn == c_PAR_W'(i));
                k = k + 1;
            end
        end
        w_par    = ^r_cw;
        w_single = (w_syn != '0) && w_par;
        w_double = (w_syn != '0) && !w_par;
    end

    assign full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign empty = (r_count == '0);
    assign busy  = (r_state != c_IDLE);
    assign w_push = wr_en && !full;
    assign w_pop  = (r_state == c_CHECK) && (!w_double || int'(r_attempt) >= MAX_RETRY);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= encode(data_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= c_IDLE;
            r_attempt  <= '0;
            r_cw       <= '0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
            r_corr     <= '0;
            r_uncorr   <= '0;
        end else begin
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_drop     <= 1'b0;
            r_overflow <= wr_en && full;
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            case (r_state)
                c_IDLE: begin
                    if (rd_en && !empty) begin
                        r_state   <= c_FETCH;
                        r_attempt <= '0;
                    end
                end
                c_FETCH: begin
                    r_cw    <= r_mem[r_rptr] ^ w_mask;
                    r_state <= c_CHECK;
                end
                c_CHECK: begin
                    if (!w_double) begin
                        r_ack   <= 1'b1;
                        r_data  <= w_data;
                        r_state <= c_IDLE;
                        if (w_single && r_corr != '1) r_corr <= r_corr + 1'b1;
                    end else begin
                        r_nack <= 1'b1;
                        if (r_uncorr != '1) r_uncorr <= r_uncorr + 1'b1;
                        if (int'(r_attempt) < MAX_RETRY) begin
                            r_attempt <= r_attempt + c_ATT_W'(1);
                            r_state   <= c_FETCH;
                        end else begin
                            r_drop  <= 1'b1;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_out   = r_data;
    assign ack        = r_ack;
    assign nack       = r_nack;
    assign drop       = r_drop;
    assign overflow   = r_overflow;
    assign count      = r_count;
    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_uncorr;

endmodule
`default_nettype wire

// File: tb/tb_secded_arq_replay_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_secded_arq_replay_fifo
// Description : Self-checking bench; expected outcomes come from counting
//               injected bit flips per attempt against a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secded_arq_replay_fifo;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 4;
    localparam int c_MR    = 2;
    localparam int c_CW    = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [1:0] err_mode = '0;
    logic [3:0] err_pos = '0;
    logic [7:0] data_out;
    logic       ack, nack, drop, busy, full, empty, overflow;
    logic [2:0] count;
    logic [7:0] corr_cnt, uncorr_cnt;

    always #5 clk = ~clk;

    secded_arq_replay_fifo #(
        .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .MAX_RETRY(c_MR), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .err_mode(err_mode), .err_pos(err_pos), .data_out(data_out), .ack(ack),
        .nack(nack), .drop(drop), .busy(busy), .full(full), .empty(empty),
        .overflow(overflow), .count(count), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    int exp_corr = 0;
    int exp_uncorr = 0;

    int obs_nacks[$];
    int obs_ack, obs_drop;
    logic [7:0] obs_data;

    int e_n, e_ack, e_drop, d_corr, d_unc;

    function automatic int flips(input int m, input int p, input int a);
        if (p >= c_CW || m == 0) return 0;
        if (m == 1) return 1;
        if (m == 2) return 2;
        return (a == 0) ? 2 : 0;
    endfunction

    // Two flipped bits are uncorrectable; one flip is corrected (bit 0 is
    // overall parity only and is not counted as a correction).
    function automatic void predict(input int m, input int p);
        e_n = 0; e_ack = -1; e_drop = -1; d_corr = 0; d_unc = 0;
        for (int a = 0; a <= c_MR; a++) begin
            if (flips(m, p, a) == 2) begin
                e_n++;
                d_unc++;
                if (a == c_MR) e_drop = 2 + 2 * a;
            end else begin
                e_ack = 2 + 2 * a;
                if (flips(m, p, a) == 1 && p != 0) d_corr = 1;
                break;
            end
        end
    endfunction

    task automatic push(input logic [7:0] d, output logic ovf);
        wr_en = 1'b1;
        data_in = d;
        @(negedge clk);
        wr_en = 1'b0;
        ovf = overflow;
    endtask

    task automatic read_txn(input logic [1:0] m, input logic [3:0] p);
        obs_nacks.delete();
        obs_ack = -1;
        obs_drop = -1;
        obs_data = 'x;
        err_mode = m;
        err_pos = p;
        rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            rd_en = 1'b0;
            if (nack) obs_nacks.push_back(j);
            if (drop) obs_drop = j;
            if (ack) begin
                obs_ack = j;
                obs_data = data_out;
            end
            if (ack || drop) break;
        end
        err_mode = '0;
        err_pos = '0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (ack !== 1'b0 || nack !== 1'b0 || drop !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b%b%b want 0000", ack, nack, drop, overflow); end
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 0", data_out); end
        n_cmp++; if (busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy/empty/full got %b%b%b want 010", busy, empty, full); end
        n_cmp++; if (count !== 3'd0 || corr_cnt !== 8'd0 || uncorr_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", count, corr_cnt, uncorr_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        logic ovf;
        push(8'hA5, ovf);
        read_txn(2'b00, 4'd0);
        n_cmp++; if (obs_ack !== 2) begin n_fail++; $display("FAIL t1_ack_cycle: got %0d want 2", obs_ack); end
        n_cmp++; if (obs_data !== 8'hA5) begin n_fail++; $display("FAIL t1_data: got %0h want a5", obs_data); end
        n_cmp++; if (corr_cnt !== 8'd0 || uncorr_cnt !== 8'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL t1_state: corr %0d uncorr %0d empty %b want 0 0 1", corr_cnt, uncorr_cnt, empty); end
    endtask

    task automatic test_single();
        logic ovf;
        push(8'h3C, ovf);
        read_txn(2'b01, 4'd5);
        exp_corr++;
        n_cmp++; if (obs_ack !== 2 || obs_nacks.size() !== 0) begin n_fail++; $display("FAIL t2_ack: cycle %0d nacks %0d want 2 0", obs_ack, obs_nacks.size()); end
        n_cmp++; if (obs_data !== 8'h3C) begin n_fail++; $display("FAIL t2_data: got %0h want 3c", obs_data); end
        n_cmp++; if (corr_cnt !== 8'(exp_corr)) begin n_fail++; $display("FAIL t2_corr: got %0d want %0d", corr_cnt, exp_corr); end
    endtask

    task automatic test_retry_recover();
        logic ovf;
        push(8'h5A, ovf);
        read_txn(2'b11, 4'd2);
        exp_uncorr++;
        n_cmp++; if (obs_nacks.size() !== 1 || (obs_nacks.size() == 1 && obs_nacks[0] !== 2)) begin n_fail++; $display("FAIL t3_nack: count %0d want one at 2", obs_nacks.size()); end
        n_cmp++; if (obs_ack !== 4 || obs_data !== 8'h5A) begin n_fail++; $display("FAIL t3_ack: cycle %0d data %0h want 4 5a", obs_ack, obs_data); end
        n_cmp++; if (uncorr_cnt !== 8'(exp_uncorr) || corr_cnt !== 8'(exp_corr)) begin n_fail++; $display("FAIL t3_cnt: got %0d/%0d want %0d/%0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr); end
    endtask

    task automatic test_drop();
        logic ovf;
        push(8'h77, ovf);
        read_txn(2'b10, 4'd6);
        exp_uncorr += 3;
        n_cmp++; if (obs_nacks.size() !== 3) begin n_fail++; $display("FAIL t4_nack_count: got %0d want 3", obs_nacks.size()); end
        for (int i = 0; i < obs_nacks.size(); i++) begin
            n_cmp++; if (obs_nacks[i] !== 2 + 2 * i) begin n_fail++; $display("FAIL t4_nack_cycle: got %0d want %0d", obs_nacks[i], 2 + 2 * i); end
        end
        n_cmp++; if (obs_drop !== 6 || obs_ack !== -1) begin n_fail++; $display("FAIL t4_drop: drop %0d ack %0d want 6 -1", obs_drop, obs_ack); end
        n_cmp++; if (empty !== 1'b1 || uncorr_cnt !== 8'(exp_uncorr) || data_out !== 8'h5A) begin n_fail++; $display("FAIL t4_state: empty %b uncorr %0d data %0h want 1 %0d 5a", empty, uncorr_cnt, data_out, exp_uncorr); end
    endtask

    task automatic test_full_overflow();
        logic ovf;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i), ovf);
            n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL t5_ovf_early: got %b want 0", ovf); end
        end
        n_cmp++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL t5_full: full %b count %0d want 1 4", full, count); end
        push(8'h05, ovf);
        n_cmp++; if (ovf !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL t5_overflow: ovf %b count %0d want 1 4", ovf, count); end
        for (int i = 1; i <= 4; i++) begin
            read_txn(2'b00, 4'd0);
            n_cmp++; if (obs_ack !== 2 || obs_data !== 8'(i)) begin n_fail++; $display("FAIL t5_order: cycle %0d data %0h want 2 %0h", obs_ack, obs_data, i); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t5_empty: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic ovf;
        push(8'h11, ovf);
        rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk); wr_en = 1'b1; data_in = 8'h22;
        @(negedge clk); wr_en = 1'b0;
        n_cmp++; if (ack !== 1'b1 || data_out !== 8'h11 || count !== 3'd1 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_push: ack %b data %0h count %0d ovf %b want 1 11 1 0", ack, data_out, count, overflow); end
        read_txn(2'b00, 4'd0);
        n_cmp++; if (obs_data !== 8'h22 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_second: data %0h empty %b want 22 1", obs_data, empty); end
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), ovf);
        rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk); wr_en = 1'b1; data_in = 8'h35;
        @(negedge clk); wr_en = 1'b0;
        n_cmp++; if (ack !== 1'b1 || overflow !== 1'b1 || count !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL b2b_full_reject: ack %b ovf %b count %0d full %b want 1 1 3 0", ack, overflow, count, full); end
        for (int i = 1; i < 4; i++) begin
            read_txn(2'b00, 4'd0);
            n_cmp++; if (obs_data !== 8'h31 + 8'(i)) begin n_fail++; $display("FAIL b2b_drain: got %0h want %0h", obs_data, 8'h31 + 8'(i)); end
        end
    endtask

    task automatic test_random();
        logic ovf;
        logic [7:0] d;
        int m, p;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = 8'($urandom);
                push(d, ovf);
                n_cmp++; if (ovf !== (q.size() == c_DEPTH)) begin n_fail++; $display("FAIL rnd_ovf: got %b want %b", ovf, q.size() == c_DEPTH); end
                if (q.size() < c_DEPTH) q.push_back(d);
            end else if (q.size() == 0) begin
                rd_en = 1'b1;
                @(negedge clk); rd_en = 1'b0;
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_empty_read: busy %b want 0", busy); end
            end else begin
                m = $urandom_range(0, 3);
                p = $urandom_range(0, 15);
                predict(m, p);
                read_txn(2'(m), 4'(p));
                n_cmp++; if (obs_ack !== e_ack || obs_drop !== e_drop || obs_nacks.size() !== e_n) begin n_fail++; $display("FAIL rnd_outcome m%0d p%0d: ack %0d drop %0d nacks %0d want %0d %0d %0d", m, p, obs_ack, obs_drop, obs_nacks.size(), e_ack, e_drop, e_n); end
                if (e_ack >= 0) begin
                    n_cmp++; if (obs_data !== q[0]) begin n_fail++; $display("FAIL rnd_data m%0d p%0d: got %0h want %0h", m, p, obs_data, q[0]); end
                end
                void'(q.pop_front());
                exp_corr += d_corr;
                exp_uncorr += d_unc;
            end
            n_cmp++; if (count !== 3'(q.size()) || corr_cnt !== 8'(exp_corr) || uncorr_cnt !== 8'(exp_uncorr)) begin n_fail++; $display("FAIL rnd_counts: count %0d corr %0d uncorr %0d want %0d %0d %0d", count, corr_cnt, uncorr_cnt, q.size(), exp_corr, exp_uncorr); end
        end
        while (q.size() > 0) begin
            read_txn(2'b00, 4'd0);
            n_cmp++; if (obs_data !== q[0]) begin n_fail++; $display("FAIL rnd_drain: got %0h want %0h", obs_data, q[0]); end
            void'(q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        logic ovf;
        logic saw_nack;
        saw_nack = 1'b0;
        push(8'h77, ovf);
        err_mode = 2'b10;
        err_pos = 4'd6;
        rd_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rd_en = 1'b0;
            if (j == 2) saw_nack = nack;
        end
        n_cmp++; if (saw_nack !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t6_pre: nack %b busy %b want 1 1", saw_nack, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ack !== 1'b0 || nack !== 1'b0 || drop !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL t6_async: ack %b nack %b drop %b data %0h busy %b want 0 0 0 0 0", ack, nack, drop, data_out, busy); end
        n_cmp++; if (empty !== 1'b1 || count !== 3'd0 || corr_cnt !== 8'd0 || uncorr_cnt !== 8'd0) begin n_fail++; $display("FAIL t6_clear: empty %b count %0d corr %0d uncorr %0d want 1 0 0 0", empty, count, corr_cnt, uncorr_cnt); end
        err_mode = '0;
        err_pos = '0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_corr = 0;
        exp_uncorr = 0;
        @(negedge clk);
        push(8'hC3, ovf);
        read_txn(2'b00, 4'd0);
        n_cmp++; if (obs_ack !== 2 || obs_data !== 8'hC3 || empty !== 1'b1) begin n_fail++; $display("FAIL t6_after: ack %0d data %0h empty %b want 2 c3 1", obs_ack, obs_data, empty); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_retry_recover();
        test_drop();
        test_full_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
